key_led_ctrl: RTL and testbench

- Parametrised successor to the two-key LED counter top.
- Two debounced push-buttons (up/down) drive an LED_W-bit up/down counter shown directly on the LEDs.
- Adds three features: wrap or saturate mode, hold-to-auto-repeat, and per-key press/release flags.
- Sits directly behind the board key pins; drives the LED pins.

---
 rtl/key_pkg.sv | 29 ++
 rtl/key_debounce.sv | 141 ++++++++++++++
 rtl/key_led_ctrl.sv | 97 +++++++++
 tb/tb_key_led_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared types and helpers for the key/LED control slice.
// Debounce FSM encoding, key polarity and timer sizing.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILT_DN = 2'd1,
    DOWN    = 2'd2,
    FILT_UP = 2'd3
  } db_state_t;

  localparam logic KEY_PRESSED = 1'b0;

  // Bits needed to hold the value n itself (timers count up to n).
  function automatic int tmr_w(input int n);
    int w;
    if (n < 2) begin
      w = 1;
    end else begin
      w = $clog2(n + 1);
    end
    return w;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One key: 2-FF synchroniser, debounce FSM and hold/auto-repeat timer.
// flag/rel/step are single-cycle pulses decoded from registered state.
module key_debounce
  import key_pkg::*;
#(
  parameter int DB_CYCLES     = 1_000_000,
  parameter int HOLD_CYCLES   = 25_000_000,
  parameter int REPEAT_CYCLES = 5_000_000,
  parameter bit REPEAT_EN     = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic state,
  output logic flag,
  output logic rel,
  output logic step
);

  localparam int DW = tmr_w(DB_CYCLES);
  localparam int HW = tmr_w(max2(HOLD_CYCLES, REPEAT_CYCLES));
  localparam logic [DW-1:0] DB_LAST = DW'(DB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_N = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] REP_N = HW'(REPEAT_CYCLES);

  logic [1:0] sync_q;
  logic ks;
  logic pressed;

  db_state_t st_q, st_d;
  logic [DW-1:0] db_q, db_d;
  logic [HW-1:0] hold_q, hold_d;
  logic rep_q, rep_d;
  logic db_done;
  logic held;
  logic rep_due;
  logic rep_step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], key_in};
    end
  end

  assign ks = sync_q[1];
  assign pressed = (ks == KEY_PRESSED);
  assign db_done = (db_q == DB_LAST);

  always_comb begin
    st_d = st_q;
    db_d = db_q;
    flag = 1'b0;
    rel  = 1'b0;
    unique case (st_q)
      IDLE: begin
        if (pressed) begin
          st_d = FILT_DN;
          db_d = '0;
        end
      end
      FILT_DN: begin
        if (!pressed) begin
          st_d = IDLE;
        end else if (db_done) begin
          st_d = DOWN;
          flag = 1'b1;
        end else begin
          db_d = db_q + DW'(1);
        end
      end
      DOWN: begin
        if (!pressed) begin
          st_d = FILT_UP;
          db_d = '0;
        end
      end
      FILT_UP: begin
        if (pressed) begin
          st_d = DOWN;
        end else if (db_done) begin
          st_d = IDLE;
          rel  = 1'b1;
        end else begin
          db_d = db_q + DW'(1);
        end
      end
      default: begin
        st_d = IDLE;
      end
    endcase
  end

  // Hold timer keeps running through release bounces (FILT_UP).
  assign held = (st_q == DOWN) ||
                ((st_q == FILT_UP) && !rel);
  assign rep_due = rep_q ? (hold_q == REP_N)
                         : (hold_q == HOLD_N);
  assign rep_step = REPEAT_EN && held && rep_due;

  always_comb begin
    hold_d = hold_q;
    rep_d  = rep_q;
    if (!REPEAT_EN) begin
      hold_d = '0;
      rep_d  = 1'b0;
    end else if (flag) begin
      hold_d = HW'(1);
      rep_d  = 1'b0;
    end else if (held) begin
      if (rep_step) begin
        hold_d = HW'(1);
        rep_d  = 1'b1;
      end else begin
        hold_d = hold_q + HW'(1);
      end
    end else begin
      hold_d = '0;
      rep_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= IDLE;
      db_q   <= '0;
      hold_q <= '0;
      rep_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      db_q   <= db_d;
      hold_q <= hold_d;
      rep_q  <= rep_d;
    end
  end

  assign state = (st_q == DOWN) || (st_q == FILT_UP);
  assign step  = flag | rep_step;

endmodule

// File: rtl/key_led_ctrl.sv
// Two debounced keys drive an up/down LED counter with
// wrap/saturate mode, auto-repeat and press/release pulses.
module key_led_ctrl
  import key_pkg::*;
#(
  parameter int LED_W         = 2,
  parameter int DB_CYCLES     = 1_000_000,
  parameter int HOLD_CYCLES   = 25_000_000,
  parameter int REPEAT_CYCLES = 5_000_000,
  parameter bit REPEAT_EN     = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_in0,
  input  logic             key_in1,
  input  logic             wrap_en,
  output logic [LED_W-1:0] led,
  output logic [1:0]       key_state,
  output logic [1:0]       key_flag,
  output logic [1:0]       key_rel
);

  localparam logic [LED_W-1:0] LED_MAX = '1;

  logic [1:0] step;
  logic up_only;
  logic dn_only;
  logic [LED_W-1:0] led_q, led_d;

  key_debounce #(
    .DB_CYCLES    (DB_CYCLES),
    .HOLD_CYCLES  (HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES),
    .REPEAT_EN    (REPEAT_EN)
  ) u_key0 (
    .clk   (clk),
    .rst_n (rst_n),
    .key_in(key_in0),
    .state (key_state[0]),
    .flag  (key_flag[0]),
    .rel   (key_rel[0]),
    .step  (step[0])
  );

  key_debounce #(
    .DB_CYCLES    (DB_CYCLES),
    .HOLD_CYCLES  (HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES),
    .REPEAT_EN    (REPEAT_EN)
  ) u_key1 (
    .clk   (clk),
    .rst_n (rst_n),
    .key_in(key_in1),
    .state (key_state[1]),
    .flag  (key_flag[1]),
    .rel   (key_rel[1]),
    .step  (step[1])
  );

  // Simultaneous up and down steps cancel out.
  assign up_only = step[0] & ~step[1];
  assign dn_only = step[1] & ~step[0];

  always_comb begin
    led_d = led_q;
    unique case (1'b1)
      up_only: begin
        if (led_q == LED_MAX) begin
          led_d = wrap_en ? '0 : led_q;
        end else begin
          led_d = led_q + LED_W'(1);
        end
      end
      dn_only: begin
        if (led_q == '0) begin
          led_d = wrap_en ? LED_MAX : led_q;
        end else begin
          led_d = led_q - LED_W'(1);
        end
      end
      default: begin
        led_d = led_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q <= '0;
    end else begin
      led_q <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_key_led_ctrl.sv
// Scoreboard bench: stimulus queues expected output events,
// a negedge monitor pops and compares them with cycle gaps.
module tb_key_led_ctrl;

  localparam int DB = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic k0 = 1'b1;
  logic k1 = 1'b1;
  logic wrap_en = 1'b1;
  logic [1:0] led;
  logic [1:0] key_state;
  logic [1:0] key_flag;
  logic [1:0] key_rel;

  key_led_ctrl #(
    .LED_W        (2),
    .DB_CYCLES    (DB),
    .HOLD_CYCLES  (40),
    .REPEAT_CYCLES(16),
    .REPEAT_EN    (1'b1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_in0  (k0),
    .key_in1  (k1),
    .wrap_en  (wrap_en),
    .led      (led),
    .key_state(key_state),
    .key_flag (key_flag),
    .key_rel  (key_rel)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] flag;
    logic [1:0] rel;
    logic [1:0] step;
    logic [1:0] led;
    int         gap;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int fails = 0;

  task automatic push(input logic [1:0] f, input logic [1:0] r,
                      input logic [1:0] s, input logic [1:0] l,
                      input int g);
    exp_t e;
    e.flag = f;
    e.rel  = r;
    e.step = s;
    e.led  = l;
    e.gap  = g;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [1:0] act,
                     input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [1:0] m, input logic p);
    if (m[0]) k0 = ~p;
    if (m[1]) k1 = ~p;
  endtask

  // Bouncy press and release around a stable low of `hold` cycles.
  task automatic drive_press(input logic [1:0] m, input int hold);
    drive(m, 1'b1);
    tick(1);
    drive(m, 1'b0);
    tick(1);
    drive(m, 1'b1);
    tick(hold);
    chk("state_held", key_state, m);
    drive(m, 1'b0);
    tick(1);
    drive(m, 1'b1);
    tick(1);
    drive(m, 1'b0);
    tick(25);
    chk("state_rel", key_state, 2'b00);
  endtask

  // Single-key or dual-key press shorter than the hold time.
  task automatic press(input logic [1:0] m, input int hold,
                       input logic [1:0] lb, input logic [1:0] la);
    push(m, 2'b00, m, lb, -1);
    if (la != lb) begin
      push(2'b00, 2'b00, 2'b00, la, 1);
      push(2'b00, m, 2'b00, la, hold + 1);
    end else begin
      push(2'b00, m, 2'b00, la, hold + 2);
    end
    drive_press(m, hold);
  endtask

  initial begin : monitor
    exp_t e;
    int ncyc;
    int last_cyc;
    int g;
    bit was_low;
    logic [1:0] prev_led;
    logic [1:0] stp;
    ncyc = 0;
    last_cyc = 0;
    was_low = 1'b1;
    prev_led = 2'b00;
    forever begin
      @(negedge clk);
      ncyc++;
      stp = {dut.u_key1.step, dut.u_key0.step};
      if (!rst_n) begin
        was_low = 1'b1;
        prev_led = led;
      end else begin
        if (was_low) begin
          last_cyc = ncyc;
          was_low = 1'b0;
        end
        if (key_flag != 2'b00 || key_rel != 2'b00 ||
            stp != 2'b00 || led != prev_led) begin
          g = ncyc - last_cyc;
          checks++;
          if (q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_evt @%0d: flag=%b rel=%b step=%b led=%0d",
                     ncyc, key_flag, key_rel, stp, led);
          end else begin
            e = q.pop_front();
            if (key_flag !== e.flag || key_rel !== e.rel ||
                stp !== e.step || led !== e.led ||
                (e.gap >= 0 && g != e.gap)) begin
              fails++;
              $display("FAIL evt @%0d: flag=%b rel=%b step=%b led=%0d gap=%0d want flag=%b rel=%b step=%b led=%0d gap=%0d",
                       ncyc, key_flag, key_rel, stp, led, g,
                       e.flag, e.rel, e.step, e.led, e.gap);
            end
          end
          last_cyc = ncyc;
        end
        prev_led = led;
      end
    end
  end

  initial begin
    tick(2);
    chk("rst_led", led, 2'd0);
    chk("rst_state", key_state, 2'b00);
    chk("rst_flag", key_flag, 2'b00);
    chk("rst_rel", key_rel, 2'b00);
    rst_n = 1'b1;
    tick(5);

    press(2'b01, 20, 2'd0, 2'd1);
    press(2'b01, 20, 2'd1, 2'd2);

    for (int i = 0; i < 10; i++) begin
      k0 = i[0];
      tick(3);
    end
    k0 = 1'b1;
    tick(20);
    chk("bounce_led", led, 2'd2);

    press(2'b01, 20, 2'd2, 2'd3);
    press(2'b01, 20, 2'd3, 2'd0);
    chk("wrap_up_led", led, 2'd0);
    wrap_en = 1'b0;
    press(2'b10, 20, 2'd0, 2'd0);
    chk("sat_dn_led", led, 2'd0);
    wrap_en = 1'b1;
    press(2'b10, 20, 2'd0, 2'd3);
    chk("wrap_dn_led", led, 2'd3);

    wrap_en = 1'b0;
    push(2'b10, 2'b00, 2'b10, 2'd3, -1);
    push(2'b00, 2'b00, 2'b00, 2'd2, 1);
    push(2'b00, 2'b00, 2'b10, 2'd2, 39);
    push(2'b00, 2'b00, 2'b00, 2'd1, 1);
    push(2'b00, 2'b00, 2'b10, 2'd1, 15);
    push(2'b00, 2'b00, 2'b00, 2'd0, 1);
    push(2'b00, 2'b00, 2'b10, 2'd0, 15);
    push(2'b00, 2'b10, 2'b00, 2'd0, 10);
    drive_press(2'b10, 80);
    chk("repeat_led", led, 2'd0);

    press(2'b11, 20, 2'd0, 2'd0);
    chk("both_led", led, 2'd0);

    wrap_en = 1'b1;
    press(2'b01, 20, 2'd0, 2'd1);

    k0 = 1'b0;
    tick(5);
    rst_n = 1'b0;
    tick(3);
    chk("mid_rst_led", led, 2'd0);
    chk("mid_rst_state", key_state, 2'b00);
    chk("mid_rst_flag", key_flag, 2'b00);
    chk("mid_rst_rel", key_rel, 2'b00);
    push(2'b01, 2'b00, 2'b01, 2'd0, 2 + DB);
    push(2'b00, 2'b00, 2'b00, 2'd1, 1);
    push(2'b00, 2'b01, 2'b00, 2'd1, 19);
    rst_n = 1'b1;
    tick(20);
    k0 = 1'b1;
    tick(30);
    chk("mid_rst_end_led", led, 2'd1);

    tick(10);
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL missing_evts: got %0d pending want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
